// File: rtl/en_dff_if.sv
// rtl/en_dff_if.sv - load enable, data in and registered data out of an enabled register chain
interface en_dff_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (
        output en,
        output d,
        input  q
    );

    modport slave (
        input  en,
        input  d,
        output q
    );
endinterface

// File: rtl/en_dff.sv
// rtl/en_dff.sv - DEPTH-stage enabled D register chain with synchronous active-low reset
module en_dff #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    en_dff_if.slave bus
);
    logic [WIDTH-1:0] stage [DEPTH];

    // en is a plain load enable; the clock is never gated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else if (bus.en) begin
            stage[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign bus.q = stage[DEPTH-1];
endmodule

// File: tb/tb_en_dff.sv
// tb/tb_en_dff.sv - scoreboard bench for en_dff in default and DEPTH=3/WIDTH=8 configurations
module tb_en_dff;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    en_dff_if #(.WIDTH(1)) bus1 ();
    en_dff_if #(.WIDTH(8)) bus3 ();

    en_dff dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    en_dff #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: each config is a FIFO of the last DEPTH loaded values; q is the oldest.
    logic       m1 [$];
    logic [7:0] m3 [$];
    logic       exp1 [$];
    logic [7:0] exp3 [$];
    bit         started = 0;

    task automatic step(input logic r, input logic e, input logic dv1, input logic [7:0] dv3);
        @(negedge clk);
        rst_n   = r;
        bus1.en = e;
        bus1.d  = dv1;
        bus3.en = e;
        bus3.d  = dv3;
        if (!r) begin
            m1 = {1'b0};
            m3 = {8'h00, 8'h00, 8'h00};
            started = 1;
        end else if (e && started) begin
            m1.push_back(dv1);
            void'(m1.pop_front());
            m3.push_back(dv3);
            void'(m3.pop_front());
        end
        if (started) begin
            exp1.push_back(m1[0]);
            exp3.push_back(m3[0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp1.size() > 0) begin
            logic e1;
            e1 = exp1.pop_front();
            vectors++;
            if (bus1.q !== e1) begin
                miscompares++;
                $display("FAIL q_depth1 at %0t: got %b expected %b", $time, bus1.q, e1);
            end
        end
        if (exp3.size() > 0) begin
            logic [7:0] e3;
            e3 = exp3.pop_front();
            vectors++;
            if (bus3.q !== e3) begin
                miscompares++;
                $display("FAIL q_depth3 at %0t: got %h expected %h", $time, bus3.q, e3);
            end
        end
    end

    initial begin
        int budget;
        bus1.en = 1'b0; bus1.d = 1'b0;
        bus3.en = 1'b0; bus3.d = 8'h00;

        // Reset held two edges with en=1, d=1
        step(0, 1, 1, 8'hff);
        step(0, 1, 1, 8'hff);
        // Enable low, d toggling
        step(1, 0, 0, 8'h5a);
        step(1, 0, 1, 8'ha5);
        step(1, 0, 0, 8'h5a);
        step(1, 0, 1, 8'ha5);
        step(1, 0, 0, 8'h5a);
        // Load with default params: d=0 x3, then d=1
        step(1, 1, 0, 8'h11);
        step(1, 1, 0, 8'h22);
        step(1, 1, 0, 8'h33);
        step(1, 1, 1, 8'h44);
        step(1, 1, 1, 8'h55);
        // Enable drop: hold 4 edges with d=0, then reload 0
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 1, 0, 8'h66);
        // Reset priority over en
        step(1, 1, 1, 8'h77);
        step(0, 1, 1, 8'h88);
        step(1, 1, 1, 8'h99);
        // DEPTH=3 chain: fill, stall 2 edges, resume
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h11);
        step(1, 1, 1, 8'h22);
        step(1, 1, 0, 8'h33);
        step(1, 0, 1, 8'hee);
        step(1, 0, 0, 8'hdd);
        step(1, 1, 1, 8'h44);
        step(1, 1, 0, 8'h55);
        step(1, 1, 1, 8'h66);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) < 6),
                 1'($urandom()), 8'($urandom()));
        end

        budget = 0;
        while ((exp1.size() > 0 || exp3.size() > 0) && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        if (exp1.size() > 0 || exp3.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", exp1.size(), exp3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
